// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Multi-cycle data-memory responder for the core's load/store port. It
//   accepts one word request at a time (valid/ready), services it LATENCY
//   cycles after acceptance, and returns a one-cycle response pulse.
//   Misaligned or out-of-range accesses are flagged and counted.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   reset       synchronous active-high reset (memory contents preserved)
//   req_valid   request present
//   req_write   1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data
//   req_ready   responder idle and able to accept this cycle
//   resp_valid  one-cycle response pulse
//   resp_rdata  load data (0 for stores, errors and idle cycles)
//   resp_err    access was misaligned or out of range
//   err_count   saturating count of errored accesses
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int AW      = 8,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [7:0]  err_count
);

    generate
        if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be within 1..255");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;

    // Request captured at acceptance; inputs are ignored while BUSY.
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        r_resp_valid;
    logic        r_resp_err;
    logic        r_resp_load;
    logic [7:0]  r_err_count;

    logic [31:0] r_mem [0:(1 << AW) - 1];
    logic [31:0] r_rd_data;

    logic          w_accept;
    logic          w_complete;
    logic          w_err;
    logic [AW-1:0] w_idx;

    assign req_ready  = (r_state == IDLE) && !reset;
    assign w_accept   = req_valid && req_ready;
    // Gating with reset makes a reset edge abort the in-flight access:
    // no array write and no response pulse.
    assign w_complete = (r_state == BUSY) && (r_cnt == 8'd0) && !reset;

    assign w_err = (r_addr[1:0] != 2'b00) || ((r_addr >> (AW + 2)) != 32'd0);
    assign w_idx = r_addr[AW+1:2];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_next = BUSY;
                    w_cnt_next   = 8'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 8'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_load  <= 1'b0;
            r_err_count  <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_resp_valid <= w_complete;
            r_resp_err   <= w_complete && w_err;
            r_resp_load  <= w_complete && !w_err && !r_write;
            if (w_complete && w_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Plain write port plus registered read so the array maps onto block RAM.
    // The read register is sampled every edge; its value only reaches
    // resp_rdata when the completing access was an error-free load.
    always_ff @(posedge clk) begin
        if (w_complete && r_write && !w_err) begin
            r_mem[w_idx] <= r_wdata;
        end
        r_rd_data <= r_mem[w_idx];
    end

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_load ? r_rd_data : 32'd0;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for dmem_responder. Two instances run side by side:
//   index 0 with LATENCY=3, index 1 with LATENCY=1 (both AW=8). Each accepted
//   request pushes its expected response into a per-instance queue; every
//   response pulse pops and compares data, error flag and latency.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    typedef struct packed {
        logic        wr;
        logic        err;
        logic [7:0]  idx;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          acc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        v   [2];
    logic        w   [2];
    logic [31:0] ad  [2];
    logic [31:0] wd  [2];
    logic        rdy [2];
    logic        rv  [2];
    logic [31:0] rd  [2];
    logic        re  [2];
    logic [7:0]  ec  [2];

    exp_t        q   [2][$];
    logic [31:0] mm  [2][256];
    logic        acc [2];
    int          lat [2];
    int          cyc;
    int          total;
    int          bad;

    dmem_responder #(.AW(8), .LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid(v[0]), .req_write(w[0]), .req_addr(ad[0]), .req_wdata(wd[0]),
        .req_ready(rdy[0]), .resp_valid(rv[0]), .resp_rdata(rd[0]),
        .resp_err(re[0]), .err_count(ec[0])
    );

    dmem_responder #(.AW(8), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(v[1]), .req_write(w[1]), .req_addr(ad[1]), .req_wdata(wd[1]),
        .req_ready(rdy[1]), .resp_valid(rv[1]), .resp_rdata(rd[1]),
        .resp_err(re[1]), .err_count(ec[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] cur, input int c);
        exp_t e;
        e.wr    = wr;
        e.err   = (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
        e.idx   = a[9:2];
        e.wdata = d;
        e.rdata = (!wr && !e.err) ? cur : 32'd0;
        e.acc   = c;
        return e;
    endfunction

    task automatic resp_chk(input int id);
        exp_t e;
        if (rv[id]) begin
            if (q[id].size() == 0) begin
                chk($sformatf("d%0d_unexpected_resp", id), {31'd0, rv[id]}, 32'd0);
            end else begin
                e = q[id].pop_front();
                chk($sformatf("d%0d_rdata@%0d", id, cyc), rd[id], e.rdata);
                chk($sformatf("d%0d_err@%0d", id, cyc), {31'd0, re[id]}, {31'd0, e.err});
                chk($sformatf("d%0d_latency@%0d", id, cyc), cyc - e.acc, lat[id]);
                if (e.wr && !e.err) mm[id][e.idx] = e.wdata;
            end
        end else begin
            chk($sformatf("d%0d_idle_rdata@%0d", id, cyc), rd[id], 32'd0);
            chk($sformatf("d%0d_idle_err@%0d", id, cyc), {31'd0, re[id]}, 32'd0);
        end
    endtask

    // One clock: note accepts just before the edge, check responses #1 after.
    task automatic tick();
        logic a [2];
        logic rst_now;
        rst_now = reset;
        for (int i = 0; i < 2; i++) a[i] = v[i] && rdy[i];
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            acc[i] = a[i];
            if (a[i]) q[i].push_back(mk(w[i], ad[i], wd[i], mm[i][ad[i][9:2]], cyc));
        end
        #1;
        if (rst_now) begin
            q[0].delete();
            q[1].delete();
        end
        for (int i = 0; i < 2; i++) resp_chk(i);
    endtask

    task automatic drive(input int id, input logic wr, input logic [31:0] a, input logic [31:0] d);
        v[id]  = 1'b1;
        w[id]  = wr;
        ad[id] = a;
        wd[id] = d;
    endtask

    task automatic send(input int id, input logic wr, input logic [31:0] a, input logic [31:0] d);
        drive(id, wr, a, d);
        acc[id] = 1'b0;
        for (int k = 0; k < 20 && !acc[id]; k++) tick();
        chk($sformatf("d%0d_send_accept", id), {31'd0, acc[id]}, 32'd1);
        v[id] = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && k < 50) begin
            tick();
            k++;
        end
        chk("drain_pending", q[0].size() + q[1].size(), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        lat[0] = 3;
        lat[1] = 1;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; w[i] = 1'b0; ad[i] = 32'd0; wd[i] = 32'd0; acc[i] = 1'b0;
            for (int j = 0; j < 256; j++) mm[i][j] = 32'd0;
        end

        // Reset state
        reset = 1'b1;
        tick();
        chk("rst_ready_low", {31'd0, rdy[0]}, 32'd0);
        chk("rst_resp_valid", {31'd0, rv[0]}, 32'd0);
        chk("rst_err_count", {24'd0, ec[0]}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, rdy[0]}, 32'd1);
        chk("post_rst_ready_l1", {31'd0, rdy[1]}, 32'd1);

        // Store 0x10, then back-to-back load of the same word
        drive(0, 1'b1, 32'h10, 32'hDEADBEEF);
        tick();
        chk("st_accept", {31'd0, acc[0]}, 32'd1);
        v[0] = 1'b0;
        chk("st_ready_e0", {31'd0, rdy[0]}, 32'd0);
        tick();
        chk("st_ready_e1", {31'd0, rdy[0]}, 32'd0);
        chk("st_novalid_e1", {31'd0, rv[0]}, 32'd0);
        tick();
        chk("st_ready_e2", {31'd0, rdy[0]}, 32'd0);
        chk("st_novalid_e2", {31'd0, rv[0]}, 32'd0);
        tick();
        chk("st_resp_valid", {31'd0, rv[0]}, 32'd1);
        chk("st_ready_resp_cycle", {31'd0, rdy[0]}, 32'd1);
        drive(0, 1'b0, 32'h10, 32'd0);
        tick();
        chk("ld_b2b_accept", {31'd0, acc[0]}, 32'd1);
        chk("st_pulse_one_cycle", {31'd0, rv[0]}, 32'd0);
        v[0] = 1'b0;
        tick();
        tick();
        tick();
        chk("ld_resp_valid", {31'd0, rv[0]}, 32'd1);
        chk("ld_rdata", rd[0], 32'hDEADBEEF);
        tick();
        chk("ld_pulse_one_cycle", {31'd0, rv[0]}, 32'd0);

        // Misaligned load and out-of-range store (aliases word 0)
        send(0, 1'b1, 32'h0, 32'hA5A5_0000);
        send(0, 1'b1, 32'h100, 32'h0000_CAFE);
        drain();
        send(0, 1'b0, 32'h12, 32'd0);
        drain();
        send(0, 1'b1, 32'h400, 32'hFFFF_FFFF);
        drain();
        chk("err_count_2", {24'd0, ec[0]}, 32'd2);
        send(0, 1'b0, 32'h0, 32'd0);
        drain();
        send(0, 1'b0, 32'h100, 32'd0);
        drain();

        // LATENCY=1: held valid, one response every 2 cycles
        for (int i = 0; i < 4; i++) begin
            send(1, 1'b1, 32'(i * 4), 32'h1111_0000 + 32'(i));
            drain();
        end
        drive(1, 1'b0, 32'h0, 32'd0);
        chk("l1_ready_start", {31'd0, rdy[1]}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("l1_ready_%0d", i), {31'd0, rdy[1]}, {31'd0, (i % 2 == 1)});
            chk($sformatf("l1_valid_%0d", i), {31'd0, rv[1]}, {31'd0, (i % 2 == 1)});
            if (acc[1]) begin
                if (ad[1] == 32'hC) v[1] = 1'b0;
                else ad[1] = ad[1] + 32'd4;
            end
        end
        chk("l1_queue_empty", q[1].size(), 32'd0);

        // Reset while a store is in flight
        send(0, 1'b1, 32'h20, 32'd0);
        drain();
        drive(0, 1'b1, 32'h20, 32'h1234_5678);
        tick();
        chk("abort_accept", {31'd0, acc[0]}, 32'd1);
        v[0] = 1'b0;
        tick();
        reset = 1'b1;
        drive(0, 1'b1, 32'h20, 32'h5555_5555);
        tick();
        chk("rst_accept_discarded", {31'd0, acc[0]}, 32'd0);
        reset = 1'b0;
        v[0]  = 1'b0;
        #1;
        chk("abort_ready", {31'd0, rdy[0]}, 32'd1);
        chk("abort_err_count", {24'd0, ec[0]}, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        send(0, 1'b0, 32'h20, 32'd0);
        drain();

        // Error counter saturation
        for (int i = 0; i < 256; i++) begin
            send(0, 1'b0, 32'h1, 32'd0);
            drain();
        end
        chk("err_sat_255", {24'd0, ec[0]}, 32'd255);
        send(0, 1'b1, 32'h800, 32'd7);
        drain();
        chk("err_sat_hold", {24'd0, ec[0]}, 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
